// File: rtl/present_decrypt_if.sv
// Request/result bundle for the PRESENT-80 decrypt core.
// The core uses the slave modport; the requester uses the master modport.
interface present_decrypt_if;
    logic        i_start;
    logic [79:0] i_key;
    logic [63:0] i_ciphertext;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_plaintext;

    modport slave (
        input  i_start,
        input  i_key,
        input  i_ciphertext,
        output o_busy,
        output o_done,
        output o_plaintext
    );

    modport master (
        output i_start,
        output i_key,
        output i_ciphertext,
        input  o_busy,
        input  o_done,
        input  o_plaintext
    );
endinterface

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption, one round per clock: forward key expansion to K32, then inverse rounds.
// Optional macro PRESENT_KEY_CACHE_EN keeps the last key and its K32 so a repeated key skips expansion.
module present_decrypt #(
    parameter int ROUNDS = 31
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    present_decrypt_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_KEYEXP = 2'd1;
    localparam logic [1:0] ST_WHITEN = 2'd2;
    localparam logic [1:0] ST_ROUND  = 2'd3;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    logic [1:0]  r_fsm;
    logic [4:0]  r_count;
    logic [79:0] r_key;
    logic [63:0] r_state;
    logic [63:0] r_plain;
    logic        r_done;

`ifdef PRESENT_KEY_CACHE_EN
    logic [79:0] r_job_key;
    logic [79:0] r_cache_key;
    logic [79:0] r_cache_k32;
    logic        r_cache_valid;
    logic        w_cache_hit;

    assign w_cache_hit = r_cache_valid && (bus.i_key == r_cache_key);
`endif

    // Forward schedule step: rotate left 61, S on top nibble, counter into bits 19:15.
    logic [79:0] w_fwd_rot;
    logic [79:0] w_fwd_key;
    assign w_fwd_rot = {r_key[18:0], r_key[79:19]};
    assign w_fwd_key = {sbox(w_fwd_rot[79:76]), w_fwd_rot[75:20],
                        w_fwd_rot[19:15] ^ r_count, w_fwd_rot[14:0]};

    // Backward schedule step undoes the forward one in reverse order.
    logic [79:0] w_inv_xor;
    logic [79:0] w_inv_sub;
    logic [79:0] w_inv_key;
    assign w_inv_xor = {r_key[79:20], r_key[19:15] ^ r_count, r_key[14:0]};
    assign w_inv_sub = {inv_sbox(w_inv_xor[79:76]), w_inv_xor[75:0]};
    assign w_inv_key = {w_inv_sub[60:0], w_inv_sub[79:61]};

    logic [63:0] w_perm;
    logic [63:0] w_sub;
    logic [63:0] w_round_state;

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_inv_perm
            if (gi == 63) begin : g_fixed
                assign w_perm[gi] = r_state[63];
            end else begin : g_moved
                assign w_perm[gi] = r_state[(16 * gi) % 63];
            end
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sbox
            assign w_sub[4*gi +: 4] = inv_sbox(w_perm[4*gi +: 4]);
        end
    endgenerate

    assign w_round_state = w_sub ^ w_inv_key[79:16];

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_fsm   <= ST_IDLE;
            r_count <= '0;
            r_key   <= '0;
            r_state <= '0;
            r_plain <= '0;
            r_done  <= 1'b0;
`ifdef PRESENT_KEY_CACHE_EN
            r_job_key     <= '0;
            r_cache_key   <= '0;
            r_cache_k32   <= '0;
            r_cache_valid <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= bus.i_ciphertext;
                        r_count <= 5'd1;
`ifdef PRESENT_KEY_CACHE_EN
                        r_job_key <= bus.i_key;
                        if (w_cache_hit) begin
                            r_key <= r_cache_k32;
                            r_fsm <= ST_WHITEN;
                        end else begin
                            r_key <= bus.i_key;
                            r_fsm <= ST_KEYEXP;
                        end
`else
                        r_key <= bus.i_key;
                        r_fsm <= ST_KEYEXP;
`endif
                    end
                end
                ST_KEYEXP: begin
                    r_key <= w_fwd_key;
                    if (r_count == LAST_ROUND) begin
                        r_fsm <= ST_WHITEN;
`ifdef PRESENT_KEY_CACHE_EN
                        r_cache_key   <= r_job_key;
                        r_cache_k32   <= w_fwd_key;
                        r_cache_valid <= 1'b1;
`endif
                    end else begin
                        r_count <= r_count + 5'd1;
                    end
                end
                ST_WHITEN: begin
                    r_state <= r_state ^ r_key[79:16];
                    r_count <= LAST_ROUND;
                    r_fsm   <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_state <= w_round_state;
                    r_key   <= w_inv_key;
                    if (r_count == 5'd1) begin
                        r_plain <= w_round_state;
                        r_done  <= 1'b1;
                        r_fsm   <= ST_IDLE;
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy      = (r_fsm != ST_IDLE);
    assign bus.o_done      = r_done;
    assign bus.o_plaintext = r_plain;

endmodule

// File: tb/tb_present_decrypt.sv
// Self-checking bench for present_decrypt: known vectors, random jobs against a PRESENT-80 encryption
// model, ignored start, mid-job reset and back-to-back jobs (latency depends on PRESENT_KEY_CACHE_EN).
module tb_present_decrypt;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    present_decrypt_if bus ();

    present_decrypt #(.ROUNDS(31)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    logic        model_cache_valid = 1'b0;
    logic [79:0] model_cache_key   = '0;

    function automatic logic [3:0] model_sbox(input logic [3:0] n);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[63 - 4 * int'(n) -: 4];
    endfunction

    function automatic logic [63:0] model_encrypt(input logic [79:0] k, input logic [63:0] pt);
        logic [63:0] rk [1:32];
        logic [79:0] kr;
        logic [63:0] s;
        logic [63:0] t;
        kr = k;
        for (int i = 1; i <= 32; i++) begin
            rk[i] = kr[79:16];
            kr = {kr[18:0], kr[79:19]};
            kr[79:76] = model_sbox(kr[79:76]);
            kr[19:15] = kr[19:15] ^ 5'(i);
        end
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = model_sbox(s[4*n +: 4]);
            t = '0;
            for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (16 * b) % 63] = s[b];
            s = t;
        end
        return s ^ rk[32];
    endfunction

    function automatic int exp_latency(input logic [79:0] k);
`ifdef PRESENT_KEY_CACHE_EN
        if (model_cache_valid && k == model_cache_key) return 32;
`endif
        return 63;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_cache_valid = 1'b0;
    endtask

    // Starts a job in the current cycle and returns at #1 after the edge that raised done.
    task automatic run_job(input string name, input logic [79:0] k, input logic [63:0] ct,
                           output logic [63:0] pt, output int lat);
        int expl;
        expl = exp_latency(k);
        bus.i_start = 1'b1;
        bus.i_key = k;
        bus.i_ciphertext = ct;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_key = {16'($urandom), $urandom, $urandom};
        bus.i_ciphertext = {$urandom, $urandom};
        lat = 0;
        pt = '0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                lat = n;
                pt = bus.o_plaintext;
                break;
            end
        end
        checks++;
        if (lat != expl) begin
            errors++;
            $display("FAIL %s latency: got %0d (0 = timeout), expected %0d", name, lat, expl);
        end
        if (expl == 63) begin
            model_cache_valid = 1'b1;
            model_cache_key = k;
        end
        $display("job %s key=%h ct=%h -> pt=%h latency=%0d", name, k, ct, pt, lat);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_plaintext !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b pt=%h, expected 0 0 0",
                     bus.o_busy, bus.o_done, bus.o_plaintext);
        end
        $display("reset busy=%b done=%b pt=%h", bus.o_busy, bus.o_done, bus.o_plaintext);
    endtask

    task automatic test_vectors();
        logic [79:0] keys [4];
        logic [63:0] cts  [4];
        logic [63:0] pts  [4];
        logic [63:0] got;
        int lat;
        keys = '{80'h0, {20{4'hF}}, 80'h0, {20{4'hF}}};
        cts  = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                 64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
        pts  = '{64'h0, 64'h0, {16{4'hF}}, {16{4'hF}}};
        for (int i = 0; i < 4; i++) begin
            run_job($sformatf("vector%0d", i), keys[i], cts[i], got, lat);
            checks++;
            if (got !== pts[i]) begin
                errors++;
                $display("FAIL vector%0d plaintext: got %h, expected %h", i, got, pts[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [79:0] k;
        logic [79:0] prev_k;
        logic [63:0] pt;
        logic [63:0] got;
        int lat;
        prev_k = '0;
        for (int i = 0; i < 6; i++) begin
            k = (i % 3 == 2) ? prev_k : {16'($urandom), $urandom, $urandom};
            pt = {$urandom, $urandom};
            run_job($sformatf("random%0d", i), k, model_encrypt(k, pt), got, lat);
            checks++;
            if (got !== pt) begin
                errors++;
                $display("FAIL random%0d plaintext: got %h, expected %h", i, got, pt);
            end
            prev_k = k;
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        logic [63:0] first;
        apply_reset();
        dones = 0;
        first = '0;
        bus.i_start = 1'b1;
        bus.i_key = 80'h0;
        bus.i_ciphertext = 64'hA112FFC72F68417B;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            if (n == 10) begin
                bus.i_start = 1'b1;
                bus.i_ciphertext = 64'h5579C1387B228445;
            end
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            if (n <= 62) begin
                checks++;
                if (bus.o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ignored_busy edge %0d: got %b, expected 1", n, bus.o_busy);
                end
            end
            if (n == 63) begin
                checks++;
                if (bus.o_done !== 1'b1) begin
                    errors++;
                    $display("FAIL ignored_done_edge: done=%b at edge 63, expected 1", bus.o_done);
                end
                first = bus.o_plaintext;
            end
            if (n == 64) begin
                checks++;
                if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL ignored_idle: busy=%b done=%b, expected 0 0", bus.o_busy, bus.o_done);
                end
            end
            if (bus.o_done === 1'b1) dones++;
        end
        model_cache_valid = 1'b1;
        model_cache_key = 80'h0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignored_done_count: got %0d, expected 1", dones);
        end
        checks++;
        if (first !== {16{4'hF}} || bus.o_plaintext !== {16{4'hF}}) begin
            errors++;
            $display("FAIL ignored_result: got %h then %h, expected ffffffffffffffff", first, bus.o_plaintext);
        end
        $display("start_ignored dones=%0d pt=%h", dones, bus.o_plaintext);
    endtask

    task automatic test_reset_mid();
        logic [63:0] got;
        int lat;
        int early_done;
        early_done = 0;
        bus.i_start = 1'b1;
        bus.i_key = {20{4'hF}};
        bus.i_ciphertext = 64'hE72C46C0F5945049;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int n = 1; n <= 39; n++) begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) early_done++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_plaintext !== 64'h0 || early_done != 0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b pt=%h early_dones=%0d, expected 0 0 0 0",
                     bus.o_busy, bus.o_done, bus.o_plaintext, early_done);
        end
        rst_n = 1'b1;
        model_cache_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.o_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_done: done=%b, expected 0", bus.o_done);
            end
        end
        run_job("after_reset", {20{4'hF}}, 64'h3333DCD3213210D2, got, lat);
        checks++;
        if (got !== {16{4'hF}}) begin
            errors++;
            $display("FAIL after_reset plaintext: got %h, expected ffffffffffffffff", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got;
        int lat;
        apply_reset();
        run_job("b2b_first", 80'h0, 64'h5579C1387B228445, got, lat);
        checks++;
        if (got !== 64'h0) begin
            errors++;
            $display("FAIL b2b_first plaintext: got %h, expected 0000000000000000", got);
        end
        run_job("b2b_second", 80'h0, 64'hA112FFC72F68417B, got, lat);
        checks++;
        if (got !== {16{4'hF}}) begin
            errors++;
            $display("FAIL b2b_second plaintext: got %h, expected ffffffffffffffff", got);
        end
        run_job("b2b_third", {20{4'hF}}, 64'hE72C46C0F5945049, got, lat);
        checks++;
        if (got !== 64'h0) begin
            errors++;
            $display("FAIL b2b_third plaintext: got %h, expected 0000000000000000", got);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_key = '0;
        bus.i_ciphertext = '0;
        test_reset();
        test_vectors();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
